mmio_cmd_reader: RTL and testbench

- Processor-side reader for the filter-command mailbox word that the button-driven memory writer deposits at data-memory address 10000.
- Periodically polls that word over the data-memory read port and decodes it as a filter code (1 = filter 1, 2 = filter 2, 0 = none).
- Hands each new command to the filter controller via a valid/ready handshake.
- Sits between data memory and the image-filter control logic.

---
 rtl/mmio_cmd_reader.sv | 125 ++++++++++++
 tb/tb_mmio_cmd_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_cmd_reader.sv
// Polls the filter-command mailbox word in data memory and offers each new
// legal filter code (1 or 2) to the filter controller over a valid/ready handshake.
module mmio_cmd_reader #(
   parameter int unsigned CMD_ADDR    = 10000,
   parameter int unsigned IDLE_ADDR   = 16,
   parameter int unsigned POLL_PERIOD = 1024,
   parameter int unsigned RD_LATENCY  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        poll_en,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [31:0] cmd_data,
   output logic        cmd_err,
   output logic        busy
);

   localparam int CNT_W = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
   localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_PERIOD - 1);
   localparam logic [1:0]       WAIT_INIT = 2'(RD_LATENCY - 1);
   localparam logic [31:0]      ADDR_CMD  = 32'(CMD_ADDR);
   localparam logic [31:0]      ADDR_IDLE = 32'(IDLE_ADDR);

   typedef enum logic [2:0] {
      s_idle,
      s_read,
      s_wait,
      s_check,
      s_offer
   } state_t;

   // state is kept as a named typed register so checkers can bind to it
   state_t           state;
   logic [CNT_W-1:0] poll_cnt;
   logic [1:0]       wait_cnt;
   logic [31:0]      rd_q;
   logic [31:0]      last_cmd;

   // Handshake: a command transfers on any rising edge where cmd_valid and
   // cmd_ready are both 1; cmd_data is held constant while cmd_valid is 1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= s_idle;
         poll_cnt  <= '0;
         wait_cnt  <= '0;
         rd_q      <= '0;
         last_cmd  <= '0;
         mem_rd_en <= 1'b0;
         mem_addr  <= ADDR_IDLE;
         cmd_valid <= 1'b0;
         cmd_data  <= '0;
         cmd_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            s_idle: begin
               if (poll_en) begin
                  if (poll_cnt == POLL_LAST) begin
                     poll_cnt  <= '0;
                     state     <= s_read;
                     mem_rd_en <= 1'b1;
                     mem_addr  <= ADDR_CMD;
                     busy      <= 1'b1;
                  end else begin
                     poll_cnt <= poll_cnt + CNT_W'(1);
                  end
               end
            end
            s_read: begin
               mem_rd_en <= 1'b0;
               wait_cnt  <= WAIT_INIT;
               state     <= s_wait;
            end
            s_wait: begin
               if (wait_cnt == 2'd0) begin
                  rd_q     <= mem_rdata;
                  mem_addr <= ADDR_IDLE;
                  state    <= s_check;
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            s_check: begin
               if (rd_q == last_cmd) begin
                  state <= s_idle;
                  busy  <= 1'b0;
               end else if (rd_q == 32'd0) begin
                  // a zero word re-arms, letting the same filter fire again
                  last_cmd <= '0;
                  state    <= s_idle;
                  busy     <= 1'b0;
               end else if (rd_q == 32'd1 || rd_q == 32'd2) begin
                  cmd_data  <= rd_q;
                  cmd_valid <= 1'b1;
                  state     <= s_offer;
               end else begin
                  cmd_err <= 1'b1;
                  state   <= s_idle;
                  busy    <= 1'b0;
               end
            end
            s_offer: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  last_cmd  <= cmd_data;
                  state     <= s_idle;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= s_idle;
               mem_rd_en <= 1'b0;
               mem_addr  <= ADDR_IDLE;
               cmd_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_cmd_reader.sv
// Directed bench for mmio_cmd_reader: a latency-accurate mailbox memory model,
// a transfer scoreboard, and immediate-assertion checks at every step.
module tb_mmio_cmd_reader;

   localparam logic [31:0] CMD_A   = 32'd10000;
   localparam logic [31:0] IDLE_A  = 32'd16;
   localparam logic [31:0] GARBAGE = 32'h0000_00A5;

   logic        clk = 1'b0;
   logic        rst_n, rst3_n, poll_en;
   logic        mem_rd_en, cmd_valid, cmd_ready, cmd_err, busy;
   logic [31:0] mem_addr, mem_rdata, cmd_data;
   logic        mem_rd_en3, cmd_valid3, cmd_ready3, cmd_err3, busy3;
   logic [31:0] mem_addr3, mem_rdata3, cmd_data3;

   logic [31:0] mem_word  = '0;
   logic [31:0] mem3_word = '0;
   logic        pipe1 = 1'b0;
   logic [2:0]  pipe3 = 3'b000;

   int checks = 0;
   int failures = 0;
   int xfers = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   mmio_cmd_reader #(.POLL_PERIOD(8), .RD_LATENCY(1)) dut (
      .clk(clk), .rst_n(rst_n), .poll_en(poll_en),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .cmd_err(cmd_err), .busy(busy)
   );

   mmio_cmd_reader #(.POLL_PERIOD(8), .RD_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst3_n), .poll_en(poll_en),
      .mem_rd_en(mem_rd_en3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3),
      .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_data(cmd_data3),
      .cmd_err(cmd_err3), .busy(busy3)
   );

   // memory returns the mailbox word only in the cycle its latency allows
   always @(posedge clk) begin
      pipe1 <= mem_rd_en;
      pipe3 <= {pipe3[1:0], mem_rd_en3};
   end
   assign mem_rdata  = pipe1    ? mem_word  : GARBAGE;
   assign mem_rdata3 = pipe3[2] ? mem3_word : GARBAGE;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every transfer must match the next expected command
   always @(negedge clk) begin
      if (rst_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
         xfers++;
         if (exp_q.size() == 0) begin
            check("xfer_unexpected", cmd_data, 32'hFFFF_FFFF);
         end else begin
            check("xfer_data", cmd_data, exp_q.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic next_poll(input string tag, input int gap);
      int n = 0;
      while (mem_rd_en !== 1'b1 && n < 2000) begin
         tick(1);
         n++;
      end
      check(tag, n, gap);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rd_en"}, mem_rd_en, 0);
      check({tag, "_addr"}, mem_addr, IDLE_A);
      check({tag, "_valid"}, cmd_valid, 0);
      check({tag, "_data"}, cmd_data, 0);
      check({tag, "_err"}, cmd_err, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   // Starts from an IDLE sample; ends at the first IDLE sample after the poll.
   task automatic do_poll(input string tag, input logic [31:0] word,
                          input bit offer, input int gap, input int hold);
      int bad = 0;
      mem_word  = word;
      cmd_ready = (hold == 0);
      next_poll({tag, "_gap"}, gap);
      check({tag, "_read_addr"}, mem_addr, CMD_A);
      check({tag, "_read_busy"}, busy, 1);
      tick(1);
      check({tag, "_wait_rd_en"}, mem_rd_en, 0);
      check({tag, "_wait_addr"}, mem_addr, CMD_A);
      tick(1);
      check({tag, "_check_addr"}, mem_addr, IDLE_A);
      check({tag, "_check_valid"}, cmd_valid, 0);
      tick(1);
      if (offer) begin
         check({tag, "_offer_valid"}, cmd_valid, 1);
         check({tag, "_offer_data"}, cmd_data, word);
         check({tag, "_offer_busy"}, busy, 1);
         if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
               tick(1);
               if (cmd_valid !== 1'b1 || cmd_data !== word || mem_rd_en !== 1'b0) bad++;
            end
            check({tag, "_hold"}, bad, 0);
            cmd_ready = 1'b1;
         end
         tick(1);
         check({tag, "_done_valid"}, cmd_valid, 0);
         check({tag, "_done_busy"}, busy, 0);
      end else begin
         check({tag, "_no_offer"}, cmd_valid, 0);
         check({tag, "_idle_busy"}, busy, 0);
      end
   endtask

   initial begin
      int seen;
      rst_n = 1'b0; rst3_n = 1'b0; poll_en = 1'b1;
      cmd_ready = 1'b0; cmd_ready3 = 1'b0;
      tick(2);
      check_reset("reset");
      rst_n = 1'b1;

      // empty mailbox: polls every 11 cycles, never an offer
      do_poll("empty0", 32'd0, 1'b0, 8, 0);
      do_poll("empty1", 32'd0, 1'b0, 8, 0);

      // filter 1 once, then repeated reads of 1 stay silent
      exp_q.push_back(32'd1);
      do_poll("cmd1", 32'd1, 1'b1, 8, 0);
      do_poll("cmd1_again", 32'd1, 1'b0, 8, 0);

      // 1 -> 2 -> 0 -> 2
      exp_q.push_back(32'd2);
      do_poll("cmd2", 32'd2, 1'b1, 8, 0);
      do_poll("clear", 32'd0, 1'b0, 8, 0);
      exp_q.push_back(32'd2);
      do_poll("cmd2_rearm", 32'd2, 1'b1, 8, 0);

      // back-pressure: offer held for 20 cycles with no polling
      do_poll("clear2", 32'd0, 1'b0, 8, 0);
      exp_q.push_back(32'd2);
      do_poll("stall", 32'd2, 1'b1, 8, 20);

      // illegal code is sticky and produces no offer
      do_poll("bad7", 32'd7, 1'b0, 8, 0);
      check("err_set", cmd_err, 1);
      exp_q.push_back(32'd1);
      do_poll("after_err", 32'd1, 1'b1, 8, 0);
      check("err_sticky", cmd_err, 1);

      // poll_en low freezes the poll counter
      tick(4);
      poll_en = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (mem_rd_en !== 1'b0) seen++;
      end
      check("poll_en_hold", seen, 0);
      poll_en = 1'b1;
      do_poll("poll_resume", 32'd1, 1'b0, 4, 0);

      // reset in OFFER drops everything at the next edge
      mem_word = 32'd2;
      cmd_ready = 1'b0;
      next_poll("rst_offer_gap", 8);
      tick(3);
      check("rst_offer_pre_valid", cmd_valid, 1);
      rst_n = 1'b0;
      tick(1);
      check_reset("rst_offer");
      rst_n = 1'b1;
      exp_q.push_back(32'd2);
      do_poll("post_rst", 32'd2, 1'b1, 8, 0);

      // RD_LATENCY=3 instance: reset in WAIT, then a clean read
      mem3_word = 32'd2;
      cmd_ready3 = 1'b1;
      rst3_n = 1'b1;
      tick(8);
      check("l3_first_rd", mem_rd_en3, 1);
      tick(2);
      check("l3_wait_addr", mem_addr3, CMD_A);
      check("l3_wait_busy", busy3, 1);
      rst3_n = 1'b0;
      tick(1);
      check("l3_rst_rd_en", mem_rd_en3, 0);
      check("l3_rst_addr", mem_addr3, IDLE_A);
      check("l3_rst_busy", busy3, 0);
      check("l3_rst_valid", cmd_valid3, 0);
      rst3_n = 1'b1;
      tick(7);
      check("l3_no_early_rd", mem_rd_en3, 0);
      tick(1);
      check("l3_rd_after_rst", mem_rd_en3, 1);
      tick(4);
      check("l3_check_valid", cmd_valid3, 0);
      tick(1);
      check("l3_offer_valid", cmd_valid3, 1);
      check("l3_offer_data", cmd_data3, 32'd2);
      check("l3_no_err", cmd_err3, 0);
      tick(1);
      check("l3_done_valid", cmd_valid3, 0);

      check("xfer_count", xfers, 6);
      check("exp_q_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
